// File: rtl/stage_execute_muldiv_pkg.sv
// Shared encodings for the execute stage: ALU, compare and mul/div op selects,
// plus the state type of the iterative mul/div sequencer.
package exec_pkg;

    localparam logic [3:0] ALUOP_ADD = 4'd0;
    localparam logic [3:0] ALUOP_SUB = 4'd1;
    localparam logic [3:0] ALUOP_AND = 4'd2;
    localparam logic [3:0] ALUOP_OR  = 4'd3;
    localparam logic [3:0] ALUOP_XOR = 4'd4;
    localparam logic [3:0] ALUOP_SHL = 4'd5;
    localparam logic [3:0] ALUOP_SHR = 4'd6;
    localparam logic [3:0] ALUOP_SRA = 4'd7;

    localparam logic [1:0] CMPOP_LTU  = 2'd0;
    localparam logic [1:0] CMPOP_LT   = 2'd1;
    localparam logic [1:0] CMPOP_EQ   = 2'd2;
    localparam logic [1:0] CMPOP_CORE = 2'd3;

    localparam logic [1:0] MDOP_MUL   = 2'd0;
    localparam logic [1:0] MDOP_MULHU = 2'd1;
    localparam logic [1:0] MDOP_DIVU  = 2'd2;
    localparam logic [1:0] MDOP_REMU  = 2'd3;

    // Fixed state codes so older tools and waveform decoders see stable values
    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_RUN  = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = MD_IDLE,
        RUN  = MD_RUN,
        DONE = MD_DONE
    } md_state_t;

endpackage

// File: rtl/stage_execute_muldiv_muldiv_iter.sv
// Iterative radix-2 multiply / divide unit: one result bit per cycle for XLEN cycles.
// The restoring divider is only built when STAGE_EXEC_DIV_EN is defined.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            ack,
    output logic            done,
    output logic            busy,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    md_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] opnd_q;
    logic [XLEN:0]   hi;
    logic [XLEN-1:0] lo;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   hi_next;
    logic [XLEN-1:0] lo_next;

`ifdef STAGE_EXEC_DIV_EN
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
`else
    logic            unused_div_sel;
    assign unused_div_sel = op_q[1];
`endif

    // {hi,lo} is shared: product shifts right for multiply, remainder/quotient shift left for divide
    always_comb begin
        mul_sum = hi + (lo[0] ? {1'b0, opnd_q} : '0);
        hi_next = {1'b0, mul_sum[XLEN:1]};
        lo_next = {mul_sum[0], lo[XLEN-1:1]};
`ifdef STAGE_EXEC_DIV_EN
        div_shift = {hi[XLEN-1:0], lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[1]) begin
            if (!div_diff[XLEN]) begin
                hi_next = div_diff;
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = div_shift;
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            opnd_q <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        cnt    <= '0;
                        hi     <= '0;
`ifdef STAGE_EXEC_DIV_EN
                        if (op[1]) begin
                            lo     <= a;
                            opnd_q <= b;
                        end else begin
                            lo     <= b;
                            opnd_q <= a;
                        end
`else
                        lo     <= b;
                        opnd_q <= a;
`endif
                        state  <= RUN;
                    end
                end
                RUN: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (op_q)
            MDOP_MULHU, MDOP_REMU: result = hi[XLEN-1:0];
            MDOP_MUL, MDOP_DIVU:   result = lo;
            default:               result = lo;
        endcase
    end

    assign done = (state == DONE);
    assign busy = (state != IDLE);

endmodule

// File: rtl/stage_execute_muldiv.sv
// Execute stage: single-cycle ALU/compare/jump-link/address generation plus an iterative mul/div.
// Define STAGE_EXEC_DIV_EN to build DIVU/REMU; otherwise those ops return 0 in one cycle.
module stage_execute_muldiv
    import exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int AW     = 4,
    parameter int CORE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CORE_W-1:0] corenum,
    input  logic [XLEN-1:0]   pc,
    input  logic              stall_in,
    output logic              stall,
    input  logic [AW-1:0]     dest,
    input  logic [3:0]        aluop,
    input  logic              is_cmp,
    input  logic              is_mul,
    input  logic [XLEN-1:0]   reg_a,
    input  logic [XLEN-1:0]   reg_b,
    input  logic [XLEN-1:0]   reg_m,
    input  logic              is_mem_in,
    input  logic              mem_write_in,
    input  logic              is_jump,
    output logic              fwd_valid,
    output logic [AW-1:0]     fwd_addr,
    output logic [XLEN-1:0]   fwd_val,
    output logic              jump,
    output logic [XLEN-1:0]   jump_addr,
    output logic [AW-1:0]     out_addr,
    output logic [XLEN-1:0]   out_val,
    output logic              is_mem,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_val,
    output logic              mem_write,
    output logic              busy
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] cmp_res;
    logic [XLEN-1:0] md_result;
    logic [XLEN-1:0] addr_sum;
    logic            md_fsm_op;
    logic            md_start;
    logic            md_done;
    logic            md_busy;
    logic            own_stall;

    assign shamt    = reg_b[SH_W-1:0];
    assign addr_sum = reg_a + reg_b;

    // A jump wins over a mul/div, so the sequencer only starts for a genuine multi-cycle op
`ifdef STAGE_EXEC_DIV_EN
    assign md_fsm_op = is_mul & ~is_jump;
`else
    assign md_fsm_op = is_mul & ~is_jump & ~aluop[1];
`endif

    assign md_start  = md_fsm_op & ~md_busy;
    assign own_stall = md_start | (md_busy & ~md_done);
    assign stall     = own_stall | stall_in;

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (aluop[1:0]),
        .a      (reg_a),
        .b      (reg_b),
        .ack    (~stall_in),
        .done   (md_done),
        .busy   (md_busy),
        .result (md_result)
    );

    always_comb begin
        case (aluop)
            ALUOP_ADD: alu_res = reg_a + reg_b;
            ALUOP_SUB: alu_res = reg_a - reg_b;
            ALUOP_AND: alu_res = reg_a & reg_b;
            ALUOP_OR:  alu_res = reg_a | reg_b;
            ALUOP_XOR: alu_res = reg_a ^ reg_b;
            ALUOP_SHL: alu_res = reg_a << shamt;
            ALUOP_SHR: alu_res = reg_a >> shamt;
            ALUOP_SRA: alu_res = $signed(reg_a) >>> shamt;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        case (aluop[1:0])
            CMPOP_LTU:  cmp_res = {{(XLEN-1){1'b0}}, reg_a < reg_b};
            CMPOP_LT:   cmp_res = {{(XLEN-1){1'b0}}, $signed(reg_a) < $signed(reg_b)};
            CMPOP_EQ:   cmp_res = {{(XLEN-1){1'b0}}, reg_a == reg_b};
            CMPOP_CORE: cmp_res = XLEN'(corenum);
            default:    cmp_res = '0;
        endcase
    end

    always_comb begin
        if (is_jump) begin
            fwd_val = pc + XLEN'(4);
        end else if (is_mul) begin
`ifdef STAGE_EXEC_DIV_EN
            fwd_val = md_result;
`else
            fwd_val = (aluop[1:0] == MDOP_DIVU || aluop[1:0] == MDOP_REMU) ? '0 : md_result;
`endif
        end else if (is_cmp) begin
            fwd_val = cmp_res;
        end else begin
            fwd_val = alu_res;
        end
    end

    assign fwd_valid = ~is_mem_in & ~(is_mul & ~md_done);
    assign fwd_addr  = dest;
    assign jump      = is_jump;
    assign jump_addr = addr_sum;
    assign mem_addr  = addr_sum;
    assign mem_val   = reg_m;
    assign mem_write = mem_write_in;
    assign busy      = md_busy;

    // Our own stall inserts bubbles downstream; a downstream stall freezes the register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr <= '0;
            out_val  <= '0;
            is_mem   <= 1'b0;
        end else if (!stall) begin
            out_addr <= dest;
            out_val  <= fwd_val;
            is_mem   <= is_mem_in;
        end else if (!stall_in) begin
            out_addr <= '0;
            out_val  <= '0;
            is_mem   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_execute_muldiv.sv
// Scoreboard bench for stage_execute_muldiv (XLEN=32): directed cases then random instructions
// against an arithmetic reference model; honours STAGE_EXEC_DIV_EN.
module tb_stage_execute_muldiv;
    import exec_pkg::*;

    localparam int XLEN   = 32;
    localparam int AW     = 4;
    localparam int CORE_W = 5;
    localparam logic [CORE_W-1:0] CORENUM = 5'd19;
`ifdef STAGE_EXEC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  aluop;
        logic        is_cmp;
        logic        is_mul;
        logic        is_jump;
        logic        is_mem;
        logic        mem_wr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m;
        logic [31:0] pc;
        logic [3:0]  dest;
    } instr_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] val;
        logic        mem;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [CORE_W-1:0] corenum;
    logic [XLEN-1:0]   pc;
    logic              stall_in;
    logic              stall;
    logic [AW-1:0]     dest;
    logic [3:0]        aluop;
    logic              is_cmp;
    logic              is_mul;
    logic [XLEN-1:0]   reg_a;
    logic [XLEN-1:0]   reg_b;
    logic [XLEN-1:0]   reg_m;
    logic              is_mem_in;
    logic              mem_write_in;
    logic              is_jump;
    logic              fwd_valid;
    logic [AW-1:0]     fwd_addr;
    logic [XLEN-1:0]   fwd_val;
    logic              jump;
    logic [XLEN-1:0]   jump_addr;
    logic [AW-1:0]     out_addr;
    logic [XLEN-1:0]   out_val;
    logic              is_mem;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_val;
    logic              mem_write;
    logic              busy;

    int   vectors;
    int   miscompares;
    exp_t exp_q[$];
    bit   mon_stop;

    stage_execute_muldiv #(
        .XLEN   (XLEN),
        .AW     (AW),
        .CORE_W (CORE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .corenum      (corenum),
        .pc           (pc),
        .stall_in     (stall_in),
        .stall        (stall),
        .dest         (dest),
        .aluop        (aluop),
        .is_cmp       (is_cmp),
        .is_mul       (is_mul),
        .reg_a        (reg_a),
        .reg_b        (reg_b),
        .reg_m        (reg_m),
        .is_mem_in    (is_mem_in),
        .mem_write_in (mem_write_in),
        .is_jump      (is_jump),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_val      (fwd_val),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .out_addr     (out_addr),
        .out_val      (out_val),
        .is_mem       (is_mem),
        .mem_addr     (mem_addr),
        .mem_val      (mem_val),
        .mem_write    (mem_write),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic from the instruction semantics
    function automatic logic [31:0] model_result(input instr_t t);
        logic [63:0] p;
        logic [4:0]  sh;
        logic [31:0] r;
        sh = t.b[4:0];
        p  = {32'b0, t.a} * {32'b0, t.b};
        if (t.is_jump) return t.pc + 32'd4;
        if (t.is_mul) begin
            case (t.aluop[1:0])
                2'd0: r = p[31:0];
                2'd1: r = p[63:32];
                2'd2: r = !DIV_EN ? 32'd0 : (t.b == 0) ? 32'hFFFF_FFFF : t.a / t.b;
                default: r = !DIV_EN ? 32'd0 : (t.b == 0) ? t.a : t.a % t.b;
            endcase
            return r;
        end
        if (t.is_cmp) begin
            case (t.aluop[1:0])
                2'd0: r = (t.a < t.b) ? 32'd1 : 32'd0;
                2'd1: r = ($signed(t.a) < $signed(t.b)) ? 32'd1 : 32'd0;
                2'd2: r = (t.a == t.b) ? 32'd1 : 32'd0;
                default: r = 32'(CORENUM);
            endcase
            return r;
        end
        if (t.aluop[3]) return 32'd0;
        case (t.aluop[2:0])
            3'd0: r = t.a + t.b;
            3'd1: r = t.a - t.b;
            3'd2: r = t.a & t.b;
            3'd3: r = t.a | t.b;
            3'd4: r = t.a ^ t.b;
            3'd5: r = t.a << sh;
            3'd6: r = t.a >> sh;
            default: r = $signed(t.a) >>> sh;
        endcase
        return r;
    endfunction

    function automatic bit multi_cycle(input instr_t t);
        return t.is_mul && !t.is_jump && (DIV_EN || !t.aluop[1]);
    endfunction

    function automatic instr_t mk(input logic [3:0] op, input bit c, input bit mul, input bit j,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] d, input logic [31:0] p);
        instr_t t;
        t = '0;
        t.aluop = op; t.is_cmp = c; t.is_mul = mul; t.is_jump = j;
        t.a = a; t.b = b; t.dest = d; t.pc = p;
        return t;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 15));
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int kind;
        kind      = $urandom_range(0, 99);
        t         = '0;
        t.aluop   = 4'($urandom_range(0, 15));
        t.a       = rand_operand();
        t.b       = rand_operand();
        t.m       = $urandom;
        t.pc      = $urandom & 32'hFFFF_FFFC;
        t.dest    = 4'($urandom_range(0, 15));
        t.is_jump = (kind < 10);
        t.is_mul  = (kind >= 10 && kind < 30) || (t.is_jump && $urandom_range(0, 2) == 0);
        t.is_cmp  = (kind >= 30 && kind < 50) || (t.is_mul && $urandom_range(0, 3) == 0);
        t.is_mem  = ($urandom_range(0, 4) == 0);
        t.mem_wr  = t.is_mem && $urandom_range(0, 1) == 1;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        aluop = t.aluop; is_cmp = t.is_cmp; is_mul = t.is_mul; is_jump = t.is_jump;
        is_mem_in = t.is_mem; mem_write_in = t.mem_wr;
        reg_a = t.a; reg_b = t.b; reg_m = t.m; pc = t.pc; dest = t.dest;
    endtask

    task automatic push_exp(input instr_t t);
        exp_t e;
        e.addr = t.dest;
        e.val  = model_result(t);
        e.mem  = t.is_mem;
        exp_q.push_back(e);
    endtask

    // Combinational outputs at the cycle the instruction is accepted
    task automatic checkOutput(input instr_t t);
        check("fwd_val",   fwd_val, model_result(t));
        check("fwd_valid", 32'(fwd_valid), (!t.is_mem && !(t.is_mul && !multi_cycle(t))) ? 32'd1 : 32'd0);
        check("fwd_addr",  32'(fwd_addr), 32'(t.dest));
        check("jump",      32'(jump), 32'(t.is_jump));
        check("jump_addr", jump_addr, t.a + t.b);
        check("mem_addr",  mem_addr, t.a + t.b);
        check("mem_val",   mem_val, t.m);
        check("mem_write", 32'(mem_write), 32'(t.mem_wr));
    endtask

    // Issue one instruction, hold it while stalled (stall_in for the first k cycles)
    task automatic applyStimulus(input instr_t t, input int k);
        int cycles;
        @(posedge clk);
        #1;
        drive(t);
        stall_in = (k > 0);
        push_exp(t);
        cycles = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            cycles++;
            if (cycles > 200) break;
            @(posedge clk);
            #1;
            if (cycles >= k) stall_in = 1'b0;
        end
        check("stall_cycles", 32'(cycles), multi_cycle(t) ? 32'(XLEN + 1) : 32'(k));
        checkOutput(t);
    endtask

    task automatic release_reset();
        instr_t nop;
        nop = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(nop);
        @(negedge clk);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        checkOutput(nop);
    endtask

    task automatic done_hold_test();
        instr_t t;
        int n;
        t = mk(4'd0, 1'b0, 1'b1, 1'b0, 32'd9, 32'd11, 4'd5, 32'h200);
        @(posedge clk);
        #1;
        drive(t);
        stall_in = 1'b1;
        push_exp(t);
        n = 0;
        forever begin
            @(negedge clk);
            if (fwd_valid || n > 100) break;
            n++;
            @(posedge clk);
            #1;
        end
        check("cycles_to_done", 32'(n), 32'(XLEN + 1));
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
                @(negedge clk);
            end
            check("done_hold_busy",  32'(busy), 32'd1);
            check("done_hold_stall", 32'(stall), 32'd1);
        end
        @(posedge clk);
        #1;
        stall_in = 1'b0;
        @(negedge clk);
        check("done_release_stall", 32'(stall), 32'd0);
        checkOutput(t);
    endtask

    task automatic reset_mid_run();
        instr_t t;
        t = mk(4'd0, 1'b0, 1'b1, 1'b0, 32'd123, 32'd456, 4'd9, 32'h300);
        @(posedge clk);
        #1;
        drive(t);
        stall_in = 1'b0;
        repeat (10) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive('0);
        exp_q.delete();
        release_reset();
    endtask

    // Monitor: tracks what the output register must hold and compares every cycle
    initial begin
        exp_t cur;
        exp_t popped;
        bit   prev_rst;
        bit   prev_stall;
        bit   prev_stall_in;
        cur           = '0;
        prev_rst      = 1'b1;
        prev_stall    = 1'b0;
        prev_stall_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_stop) begin
                if (prev_rst) begin
                    cur = '0;
                end else if (!prev_stall) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL scoreboard_underflow: got capture, required none pending");
                    end else begin
                        popped = exp_q.pop_front();
                        cur    = popped;
                    end
                end else if (!prev_stall_in) begin
                    cur = '0;
                end
                check("out_addr", 32'(out_addr), 32'(cur.addr));
                check("out_val",  out_val, cur.val);
                check("is_mem",   32'(is_mem), 32'(cur.mem));
                prev_rst      = rst;
                prev_stall    = stall;
                prev_stall_in = stall_in;
            end
        end
    end

    initial begin
        int k;
        instr_t t;
        vectors     = 0;
        miscompares = 0;
        mon_stop    = 1'b0;
        rst         = 1'b1;
        stall_in    = 1'b0;
        corenum     = CORENUM;
        drive('0);
        repeat (2) @(posedge clk);
        release_reset();

        applyStimulus(mk(ALUOP_ADD, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 4'd2, 32'h0), 0);
        applyStimulus(mk(4'd0, 1'b0, 1'b1, 1'b0, 32'd7, 32'd6, 4'd3, 32'h0), 0);
        applyStimulus(mk(4'd1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'h0), 0);
        applyStimulus(mk(4'd2, 1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 4'd5, 32'h0), 0);
        applyStimulus(mk(4'd3, 1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 4'd6, 32'h0), 0);
        applyStimulus(mk(4'd2, 1'b0, 1'b1, 1'b0, 32'd1234, 32'd0, 4'd7, 32'h0), 0);
        applyStimulus(mk(4'd3, 1'b0, 1'b1, 1'b0, 32'd1234, 32'd0, 4'd8, 32'h0), 0);
        applyStimulus(mk(4'd0, 1'b0, 1'b0, 1'b1, 32'h40, 32'd8, 4'd1, 32'h100), 0);
        applyStimulus(mk(4'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd10, 32'h0), 0);
        applyStimulus(mk(ALUOP_SRA, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'd36, 4'd11, 32'h0), 2);
        applyStimulus(mk(4'd9, 1'b0, 1'b0, 1'b0, 32'd5, 32'd6, 4'd12, 32'h0), 0);

        done_hold_test();
        reset_mid_run();

        for (int i = 0; i < 150; i++) begin
            t = rand_instr();
            k = (!multi_cycle(t) && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            applyStimulus(t, k);
        end

        @(negedge clk);
        #1;
        mon_stop = 1'b1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
